// File: rtl/cpu_ctrl_pkg.sv
// Shared control constants for the CPU sequencer and the instruction decoder:
// state encoding, opcode values, counter widths and small helpers.
package cpu_ctrl_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned OP_W    = 8;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned WAIT_W  = 8;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_FETCH  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DECODE = 3'd2;
  localparam logic [STATE_W-1:0] ST_EXEC   = 3'd3;
  localparam logic [STATE_W-1:0] ST_MEM    = 3'd4;
  localparam logic [STATE_W-1:0] ST_WB     = 3'd5;
  localparam logic [STATE_W-1:0] ST_HALTED = 3'd6;

  localparam logic [OP_W-1:0] OP_HALT  = 8'h00;
  localparam logic [OP_W-1:0] OP_LOAD  = 8'h01;
  localparam logic [OP_W-1:0] OP_STORE = 8'h02;
  localparam logic [OP_W-1:0] OP_ADD   = 8'h03;
  localparam logic [OP_W-1:0] OP_JUMP  = 8'h04;
  localparam logic [OP_W-1:0] OP_LOADI = 8'h05;

  typedef struct packed {
    logic fetch;
    logic decode;
    logic exec;
    logic wb;
  } stage_en_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control/memory handshake bundle between the sequencer and its environment.
interface cpu_sequencer_if;
  import cpu_ctrl_pkg::*;

  logic              start;
  logic              halt_req;
  logic [OP_W-1:0]   opcode;
  logic              mem_ack;
  logic              mem_req;
  logic              mem_we;
  logic              fetch_en;
  logic              decode_en;
  logic              exec_en;
  logic              wb_en;
  logic              pc_inc;
  logic              pc_load;
  logic              halted;
  logic              bus_err;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  instr_count;

  modport master (
    input  start, halt_req, opcode, mem_ack,
    output mem_req, mem_we, fetch_en, decode_en, exec_en, wb_en,
           pc_inc, pc_load, halted, bus_err, cycle_count, instr_count
  );

  modport slave (
    output start, halt_req, opcode, mem_ack,
    input  mem_req, mem_we, fetch_en, decode_en, exec_en, wb_en,
           pc_inc, pc_load, halted, bus_err, cycle_count, instr_count
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles spent waiting for a memory acknowledge and flags
// the cycle in which the wait would reach TIMEOUT.
module mem_wait_timer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // An ack in the final cycle suppresses count_i, so the ack wins.
  assign expired_o = count_i && (cnt_q == WAIT_W'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, optional memory
// and write-back phases, with halt handling and a sticky memory timeout.
module cpu_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  cpu_sequencer_if.master       bus
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [CNT_W-1:0]   instr_q, instr_d;
  logic               bus_err_q, bus_err_d;

  logic      waiting_c, expired_c, timer_clear_c, timer_count_c;
  logic      active_c, retire_c, boundary_c;
  stage_en_t stage_c;

  assign waiting_c     = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign timer_count_c = waiting_c && !bus.mem_ack;
  assign timer_clear_c = (state_d != state_q);
  assign active_c      = (state_q >= ST_FETCH) && (state_q <= ST_WB);

  mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_wait (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (timer_clear_c),
    .count_i   (timer_count_c),
    .expired_o (expired_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      cyc_q     <= '0;
      instr_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cyc_q     <= cyc_d;
      instr_q   <= instr_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state logic; boundary_c marks an instruction boundary.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    bus_err_d  = bus_err_q;
    retire_c   = 1'b0;
    boundary_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.halt_req) begin
          state_d = ST_HALTED;
        end else if (bus.start) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (bus.mem_ack) begin
          state_d = ST_DECODE;
        end else if (expired_c) begin
          state_d   = ST_HALTED;
          bus_err_d = 1'b1;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        op_d = bus.opcode;
        case (bus.opcode)
          OP_HALT: begin
            state_d  = ST_HALTED;
            retire_c = 1'b1;
          end
          OP_LOAD, OP_ADD, OP_STORE: state_d = ST_MEM;
          OP_LOADI:                  state_d = ST_WB;
          default:                   boundary_c = 1'b1;
        endcase
      end
      ST_MEM: begin
        if (bus.mem_ack) begin
          if ((op_q == OP_LOAD) || (op_q == OP_ADD)) begin
            state_d = ST_WB;
          end else begin
            boundary_c = 1'b1;
          end
        end else if (expired_c) begin
          state_d   = ST_HALTED;
          bus_err_d = 1'b1;
        end
      end
      ST_WB:     boundary_c = 1'b1;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
    if (boundary_c) begin
      retire_c = 1'b1;
      state_d  = bus.halt_req ? ST_HALTED : ST_FETCH;
    end
  end

  assign instr_d = retire_c ? instr_q + CNT_W'(1) : instr_q;
  assign cyc_d   = active_c ? sat_inc(cyc_q) : cyc_q;

  // Output decode from the registered state, plus mem_ack for pc_inc.
  always_comb begin
    stage_c     = '0;
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    bus.pc_inc  = 1'b0;
    bus.pc_load = 1'b0;
    case (state_q)
      ST_FETCH: begin
        stage_c.fetch = 1'b1;
        bus.mem_req   = 1'b1;
        bus.pc_inc    = bus.mem_ack;
      end
      ST_DECODE: stage_c.decode = 1'b1;
      ST_EXEC: begin
        stage_c.exec = 1'b1;
        bus.pc_load  = (bus.opcode == OP_JUMP);
      end
      ST_MEM: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = (op_q == OP_STORE);
      end
      ST_WB:   stage_c.wb = 1'b1;
      default: stage_c = '0;
    endcase
  end

  assign bus.fetch_en    = stage_c.fetch;
  assign bus.decode_en   = stage_c.decode;
  assign bus.exec_en     = stage_c.exec;
  assign bus.wb_en       = stage_c.wb;
  assign bus.halted      = (state_q == ST_HALTED);
  assign bus.bus_err     = bus_err_q;
  assign bus.cycle_count = cyc_q;
  assign bus.instr_count = instr_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer with MEM_TIMEOUT = 4.
module tb_cpu_sequencer;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  // Output vector: mem_req mem_we fetch decode exec wb pc_inc pc_load halted bus_err
  localparam logic [9:0] O_NONE      = 10'h000;
  localparam logic [9:0] O_FETCH     = 10'h280;
  localparam logic [9:0] O_FETCH_ACK = 10'h288;
  localparam logic [9:0] O_DEC       = 10'h040;
  localparam logic [9:0] O_EXEC      = 10'h020;
  localparam logic [9:0] O_JUMP      = 10'h024;
  localparam logic [9:0] O_MEMR      = 10'h200;
  localparam logic [9:0] O_MEMW      = 10'h300;
  localparam logic [9:0] O_WB        = 10'h010;
  localparam logic [9:0] O_HALT      = 10'h002;
  localparam logic [9:0] O_BUSERR    = 10'h003;

  cpu_sequencer_if bus ();

  cpu_sequencer #(.MEM_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] outs();
    return {bus.mem_req, bus.mem_we, bus.fetch_en, bus.decode_en, bus.exec_en,
            bus.wb_en, bus.pc_inc, bus.pc_load, bus.halted, bus.bus_err};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_o(input string tag, input logic [9:0] exp);
    #1;
    chk(tag, 32'(outs()), 32'(exp));
  endtask

  task automatic chk_cnt(input string tag, input int cycles, input int instrs);
    chk({tag, "_cycles"}, 32'(bus.cycle_count), 32'(cycles));
    chk({tag, "_instrs"}, 32'(bus.instr_count), 32'(instrs));
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.halt_req = 1'b0;
    bus.opcode   = 8'h00;
    bus.mem_ack  = 1'b0;

    // Reset state, stale ack ignored
    cyc();
    chk_o("reset_outs", O_NONE);
    chk_cnt("reset", 0, 0);
    bus.mem_ack = 1'b1;
    chk_o("reset_ack", O_NONE);
    bus.mem_ack = 1'b0;

    // LOADI with ack one cycle after request
    cyc(); rst = 1'b0; bus.start = 1'b1;
    chk_o("idle_before_start", O_NONE);
    cyc(); bus.start = 1'b0;
    chk_o("s1_fetch", O_FETCH);
    cyc(); bus.mem_ack = 1'b1;
    chk_o("s1_fetch_ack", O_FETCH_ACK);
    cyc(); bus.mem_ack = 1'b0;
    chk_o("s1_decode", O_DEC);
    cyc(); bus.opcode = 8'h05;
    chk_o("s1_exec", O_EXEC);
    cyc();
    chk_o("s1_wb", O_WB);
    chk_cnt("s1_wb", 4, 0);
    cyc();
    chk_o("s1_refetch", O_FETCH);
    chk_cnt("s1_end", 5, 1);

    // STORE with ack in the 4th MEM cycle (ack wins over timeout)
    bus.mem_ack = 1'b1;
    chk_o("s2_fetch_ack", O_FETCH_ACK);
    cyc(); bus.mem_ack = 1'b0;
    chk_o("s2_decode", O_DEC);
    cyc(); bus.opcode = 8'h02;
    chk_o("s2_exec", O_EXEC);
    for (int i = 0; i < 4; i++) begin
      cyc(); bus.mem_ack = (i == 3);
      chk_o($sformatf("s2_mem%0d", i), O_MEMW);
    end
    cyc(); bus.mem_ack = 1'b0;
    chk_o("s2_boundary", O_FETCH);
    chk_cnt("s2_end", 12, 2);

    // JUMP then an undefined opcode treated as NOP
    bus.mem_ack = 1'b1;
    chk_o("s3_fetch_ack", O_FETCH_ACK);
    cyc(); bus.mem_ack = 1'b0;
    cyc(); bus.opcode = 8'h04;
    chk_o("s3_jump_exec", O_JUMP);
    cyc();
    chk_o("s3_after_jump", O_FETCH);
    chk_cnt("s3_jump", 15, 3);
    bus.mem_ack = 1'b1;
    cyc(); bus.mem_ack = 1'b0;
    cyc(); bus.opcode = 8'hFF;
    chk_o("s3_nop_exec", O_EXEC);
    cyc();
    chk_o("s3_after_nop", O_FETCH);
    chk_cnt("s3_end", 18, 4);

    // LOAD with halt_req raised during MEM: WB completes, then HALTED
    bus.mem_ack = 1'b1;
    cyc(); bus.mem_ack = 1'b0;
    cyc(); bus.opcode = 8'h01;
    chk_o("s4_exec", O_EXEC);
    cyc(); bus.halt_req = 1'b1; bus.mem_ack = 1'b1;
    chk_o("s4_mem_read", O_MEMR);
    cyc(); bus.mem_ack = 1'b0;
    chk_o("s4_wb", O_WB);
    cyc();
    chk_o("s4_halted", O_HALT);
    chk_cnt("s4_halted", 23, 5);
    bus.halt_req = 1'b0; bus.start = 1'b1; bus.mem_ack = 1'b1;
    chk_o("s4_halted_ack", O_HALT);
    cyc(); bus.start = 1'b0; bus.mem_ack = 1'b0;
    chk_o("s4_absorbing", O_HALT);
    chk_cnt("s4_frozen", 23, 5);

    // Asynchronous reset, then fetch timeout
    #2 rst = 1'b1;
    chk_o("s5_async_rst", O_NONE);
    chk_cnt("s5_rst", 0, 0);
    cyc(); rst = 1'b0; bus.start = 1'b1;
    chk_o("s5_idle", O_NONE);
    for (int i = 0; i < 4; i++) begin
      cyc(); bus.start = 1'b0;
      chk_o($sformatf("s5_fetch_wait%0d", i), O_FETCH);
    end
    cyc();
    chk_o("s5_bus_err", O_BUSERR);
    chk_cnt("s5_end", 4, 0);

    // Halt request wins over start in IDLE
    rst = 1'b1;
    chk_o("s6_rst_clears_err", O_NONE);
    cyc(); rst = 1'b0; bus.start = 1'b1; bus.halt_req = 1'b1;
    cyc();
    chk_o("s6_idle_halt", O_HALT);

    // Ack on the 4th fetch cycle, then reset in the middle of MEM
    rst = 1'b1;
    cyc(); rst = 1'b0; bus.halt_req = 1'b0; bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); bus.start = 1'b0;
    end
    cyc(); bus.mem_ack = 1'b1;
    chk_o("s7_fetch_ack4", O_FETCH_ACK);
    cyc(); bus.mem_ack = 1'b0;
    chk_o("s7_decode_no_err", O_DEC);
    cyc(); bus.opcode = 8'h03;
    chk_o("s7_exec_add", O_EXEC);
    cyc();
    chk_o("s7_mem1", O_MEMR);
    cyc();
    chk_o("s7_mem2", O_MEMR);
    #2 rst = 1'b1;
    chk_o("s7_rst_drops_req", O_NONE);
    chk_cnt("s7_rst", 0, 0);
    cyc(); rst = 1'b0; bus.mem_ack = 1'b1;
    chk_o("s7_stale_ack", O_NONE);
    cyc(); bus.mem_ack = 1'b0;
    chk_o("s7_stay_idle", O_NONE);

    // HALT opcode retires and halts
    bus.start = 1'b1;
    cyc(); bus.start = 1'b0; bus.mem_ack = 1'b1;
    chk_o("s8_fetch_ack", O_FETCH_ACK);
    cyc(); bus.mem_ack = 1'b0;
    cyc(); bus.opcode = 8'h00;
    chk_o("s8_exec_halt", O_EXEC);
    cyc();
    chk_o("s8_halted", O_HALT);
    chk_cnt("s8_end", 3, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, 15, max cycles waiting for mem_ack before bus error (range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  level; leaves IDLE and begins fetching.
REQ-005 SHALL have port halt_req  input  1  level; external halt, honoured only at instruction boundaries.
REQ-006 SHALL have port opcode  input  8  decoder OP_code, valid during EXECUTE.
REQ-007 SHALL have port mem_ack  input  1  memory transfer complete, one-cycle pulse.
REQ-008 SHALL have ports mem_req, mem_we  output  1 each  memory request; write qualifier.
REQ-009 SHALL have ports fetch_en, decode_en, exec_en, wb_en  output  1 each  stage enables.
REQ-010 SHALL have ports pc_inc, pc_load  output  1 each  PC increment; PC load from value (jump).
REQ-011 SHALL have ports halted, bus_err  output  1 each  halt status; sticky memory timeout.
REQ-012 SHALL have ports cycle_count, instr_count  output  16 each  active cycles; retired instructions.

Function
REQ-013 SHALL implement Moore FSM states IDLE, FETCH, DECODE, EXECUTE, MEM, WB, HALTED; outputs decode from the registered state plus mem_ack.
REQ-014 IDLE: halt_req=1 -> HALTED (priority over start); else start=1 -> FETCH.
REQ-015 FETCH: mem_req=1, mem_we=0, fetch_en=1; on mem_ack -> DECODE with pc_inc=1 in the same cycle.
REQ-016 DECODE: decode_en=1 for exactly one cycle -> EXECUTE.
REQ-017 EXECUTE: exec_en=1 for one cycle; opcode latched into op_q; next state by opcode.
REQ-018 Opcode transitions: 8'h00 HALT -> HALTED; 8'h01 LOAD, 8'h03 ADD -> MEM (read); 8'h02 STORE -> MEM (mem_we=1); 8'h04 JUMP -> boundary with pc_load=1; 8'h05 LOADI -> WB; any other value is NOP -> boundary.
REQ-019 MEM: mem_req=1, mem_we=1 iff op_q=STORE; on mem_ack -> WB for LOAD/ADD, else boundary.
REQ-020 WB: wb_en=1 for one cycle -> boundary.
REQ-021 Boundary: instr_count increments (wraps at FFFF); next state is HALTED if halt_req=1, else FETCH.
REQ-022 HALTED: halted=1, all enables and mem_req 0; absorbing until rst; start ignored.
REQ-023 Wait counter SHALL clear on entry to FETCH/MEM and count cycles without mem_ack; on reaching MEM_TIMEOUT -> bus_err=1, HALTED, mem_req deasserted next cycle.
REQ-024 mem_ack in the same cycle the counter reaches MEM_TIMEOUT SHALL be treated as success (ack wins).
REQ-025 mem_ack outside FETCH/MEM SHALL be ignored.
REQ-026 cycle_count SHALL increment every cycle in FETCH..WB, saturating at 16'hFFFF.
REQ-027 HALT opcode SHALL count as retired (instr_count increments on EXECUTE -> HALTED).
REQ-028 At most one of fetch_en/decode_en/exec_en/wb_en SHALL be 1 in any cycle.

Reset
REQ-029 rst SHALL asynchronously force IDLE, op_q=0, wait counter=0, counters=0, bus_err=0; all outputs 0.
REQ-030 rst mid-transaction SHALL drop mem_req immediately; a subsequent stale mem_ack is ignored.
REQ-031 On rst deassertion, the FSM SHALL stay in IDLE until start.

Structure
REQ-032 State encoding (3-bit) and opcode constants SHALL live in shared package cpu_ctrl_pkg, used also by the decoder.
REQ-033 The wait counter and timeout compare SHALL be sub-module mem_wait_timer (clear, count, expired).
REQ-034 Targeted RTL size: 150-300 lines.

Verification
REQ-035 rst, start=1, ack 1 cycle after each req, opcode 8'h05 -> FETCH,DECODE,EXECUTE,WB,FETCH; wb_en one cycle; instr_count=1.
REQ-036 opcode 8'h02, ack delayed 3 cycles in MEM -> mem_req=1 and mem_we=1 for 4 cycles; no wb_en; then FETCH.
REQ-037 MEM_TIMEOUT=4, no ack in FETCH -> bus_err=1 and halted=1 after 4 wait cycles; ack on 4th cycle instead -> DECODE, bus_err=0.
REQ-038 halt_req=1 during LOAD MEM phase -> WB completes; next state HALTED, instr_count=1, no further fetch_en.
REQ-039 rst asserted during MEM with mem_req=1 -> mem_req=0 same cycle; later mem_ack ignored; IDLE, all counters 0.
REQ-040 Opcode 8'h04 -> pc_load=1 for one cycle in EXECUTE; pc_inc only in the FETCH ack cycle; opcode 8'hFF treated as NOP.
